oled_spi_responder: RTL

- SPI receive-side model of the SSD1306-class OLED controller: deserialises the 4-wire write-only link (sclk, sdin, dc_n, res_n) driven by the oled control/SPI master.
- Classifies bytes as command or data, parses multi-byte commands into configuration registers, and turns data bytes into framebuffer write strokes with SSD1306 pointer auto-increment.
- Used as the on-chip/bench display responder for closed-loop checking of the OLED init and character-draw sequences.

---
 rtl/oled_pkg.sv | 30 +++
 rtl/oled_spi_responder_if.sv | 27 ++
 rtl/spi_rx_shift.sv | 63 ++++++
 rtl/oled_spi_responder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: SSD1306 opcodes, configuration defaults and shared enums for the OLED link
package oled_pkg;
  localparam logic [7:0] CMD_ADDR_MODE     = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR      = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR     = 8'h22;
  localparam logic [7:0] CMD_CONTRAST      = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
  localparam logic [7:0] CMD_SEG_REMAP0    = 8'hA0;
  localparam logic [7:0] CMD_SEG_REMAP1    = 8'hA1;
  localparam logic [7:0] CMD_ENTIRE_OFF    = 8'hA4;
  localparam logic [7:0] CMD_ENTIRE_ON     = 8'hA5;
  localparam logic [7:0] CMD_DISP_OFF      = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON       = 8'hAF;
  localparam logic [7:0] CMD_PAGE_START    = 8'hB0;
  localparam logic [7:0] CMD_COM_SCAN_NORM = 8'hC0;
  localparam logic [7:0] CMD_COM_SCAN_REV  = 8'hC8;
  localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
  localparam logic [7:0] DEF_CONTRAST      = 8'h7F;
  typedef enum logic [1:0] {AM_HORZ = 2'd0, AM_VERT = 2'd1, AM_PAGE = 2'd2} addr_mode_t;
  localparam addr_mode_t DEF_ADDR_MODE = AM_PAGE;
  typedef enum logic [1:0] {P_CMD, P_ARG1, P_ARG2} parser_state_t;
  function automatic logic takes_arg(input logic [7:0] op);
    return op inside {CMD_CONTRAST, CMD_CHARGE_PUMP, CMD_PRECHARGE, CMD_COM_PINS,
                      CMD_ADDR_MODE, CMD_COL_ADDR, CMD_PAGE_ADDR};
  endfunction
  function automatic logic takes_two(input logic [7:0] op);
    return op inside {CMD_COL_ADDR, CMD_PAGE_ADDR};
  endfunction
endpackage

// File: rtl/oled_spi_responder_if.sv
// oled_spi_responder_if: SPI link inputs plus received-byte, config and framebuffer outputs
interface oled_spi_responder_if #(parameter int PAGES = 4);
  localparam int PW = $clog2(PAGES);
  logic oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n;
  logic rx_valid, rx_is_data;
  logic [7:0] rx_byte;
  logic display_on, charge_pump_en, seg_remap, com_scan_rev, entire_on;
  logic [7:0] contrast;
  logic [PW-1:0] page_ptr;
  logic [6:0] col_ptr;
  logic fb_we;
  logic [PW+6:0] fb_addr;
  logic [7:0] fb_wdata;
  logic unsupported_cmd, frame_err;
  modport master (
    output oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n,
    input rx_valid, rx_byte, rx_is_data, display_on, contrast, charge_pump_en, seg_remap,
    input com_scan_rev, entire_on, page_ptr, col_ptr, fb_we, fb_addr, fb_wdata,
    input unsupported_cmd, frame_err
  );
  modport slave (
    input oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n,
    output rx_valid, rx_byte, rx_is_data, display_on, contrast, charge_pump_en, seg_remap,
    output com_scan_rev, entire_on, page_ptr, col_ptr, fb_we, fb_addr, fb_wdata,
    output unsupported_cmd, frame_err
  );
endinterface

// File: rtl/spi_rx_shift.sv
// spi_rx_shift: synchronises the SPI pins, deserialises bytes MSB first and drops stalled partial bytes
module spi_rx_shift #(
  parameter int IDLE_TIMEOUT = 200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       sdin,
  input  logic       dc_n,
  input  logic       res_n,
  output logic       res_ok,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_is_data,
  output logic       frame_err
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [2:0] sclk_s;
  logic [1:0] sdin_s, dc_s, res_s;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [IW-1:0] idle;
  logic rise;
  assign rise = sclk_s[1] & ~sclk_s[2];
  assign res_ok = res_s[1];
  // sync pins, shift on sclk rise, emit byte on 8th bit, discard partial byte after idle timeout
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclk_s <= '1;
      sdin_s <= '0;
      dc_s <= '0;
      res_s <= '1;
      bit_cnt <= '0;
      shreg <= '0;
      idle <= '0;
      rx_valid <= 1'b0;
      rx_byte <= '0;
      rx_is_data <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      sdin_s <= {sdin_s[0], sdin};
      dc_s <= {dc_s[0], dc_n};
      res_s <= {res_s[0], res_n};
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      idle <= rise ? '0 : (idle == IW'(IDLE_TIMEOUT) ? idle : idle + 1'b1);
      if (!res_ok) bit_cnt <= '0;
      else if (rise) begin
        shreg <= {shreg[5:0], sdin_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_valid <= 1'b1;
          rx_byte <= {shreg, sdin_s[1]};
          rx_is_data <= dc_s[1];
        end
      end else if (bit_cnt != 3'd0 && idle == IW'(IDLE_TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        bit_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/oled_spi_responder.sv
// oled_spi_responder: SSD1306-style command parser and framebuffer write generator behind the SPI deserialiser
module oled_spi_responder
  import oled_pkg::*;
#(
  parameter int PAGES = 4,
  parameter int COLS = 128,
  parameter int IDLE_TIMEOUT = 200
) (
  input logic clock,
  input logic reset_n,
  oled_spi_responder_if.slave bus
);
  localparam int PW = $clog2(PAGES);
  typedef struct packed {
    parser_state_t state;
    logic [7:0] op;
    logic [6:0] arg1;
    logic display_on;
    logic [7:0] contrast;
    logic charge_pump_en;
    logic seg_remap;
    logic com_scan_rev;
    logic entire_on;
    addr_mode_t addr_mode;
    logic [6:0] col_start;
    logic [6:0] col_end;
    logic [PW-1:0] page_start;
    logic [PW-1:0] page_end;
    logic [PW-1:0] page_ptr;
    logic [6:0] col_ptr;
  } cfg_t;
  localparam cfg_t CFG_DEF = '{state: P_CMD, op: 8'h00, arg1: 7'h00, display_on: 1'b0,
    contrast: DEF_CONTRAST, charge_pump_en: 1'b0, seg_remap: 1'b0, com_scan_rev: 1'b0,
    entire_on: 1'b0, addr_mode: DEF_ADDR_MODE, col_start: 7'd0, col_end: 7'(COLS - 1),
    page_start: {PW{1'b0}}, page_end: PW'(PAGES - 1), page_ptr: {PW{1'b0}}, col_ptr: 7'd0};
  logic rx_valid, rx_is_data, res_ok;
  logic [7:0] rx_byte;
  cfg_t cfg, nx;
  logic fb_we, nx_we, unsup, nx_unsup;
  logic [PW+6:0] fb_addr, nx_addr;
  logic [7:0] fb_wdata, nx_wdata;
  logic col_wrap, page_wrap;
  logic [6:0] col_step;
  logic [PW-1:0] page_step;
  spi_rx_shift #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_rx (
    .clock(clock),
    .reset_n(reset_n),
    .sclk(bus.oled_spi_clk),
    .sdin(bus.oled_spi_data),
    .dc_n(bus.oled_dc_n),
    .res_n(bus.oled_reset_n),
    .res_ok(res_ok),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_is_data(rx_is_data),
    .frame_err(bus.frame_err)
  );
  assign col_wrap = cfg.col_ptr == cfg.col_end;
  assign page_wrap = cfg.page_ptr == cfg.page_end;
  assign col_step = col_wrap ? cfg.col_start : cfg.col_ptr + 7'd1;
  assign page_step = page_wrap ? cfg.page_start : cfg.page_ptr + 1'b1;
  // parser next state: panel reset, data writes with pointer advance, command and argument decode
  always_comb begin
    nx = cfg;
    nx_we = 1'b0;
    nx_unsup = 1'b0;
    nx_addr = fb_addr;
    nx_wdata = fb_wdata;
    if (!res_ok) nx = CFG_DEF;
    else if (rx_valid && rx_is_data) begin
      nx.state = P_CMD;
      nx_we = 1'b1;
      nx_addr = {cfg.page_ptr, cfg.col_ptr};
      nx_wdata = rx_byte;
      nx.col_ptr = cfg.addr_mode == AM_PAGE ? cfg.col_ptr + 7'd1 :
                   (cfg.addr_mode == AM_HORZ || page_wrap) ? col_step : cfg.col_ptr;
      nx.page_ptr = (cfg.addr_mode == AM_VERT || (cfg.addr_mode == AM_HORZ && col_wrap)) ?
                    page_step : cfg.page_ptr;
    end else if (rx_valid) begin
      case (cfg.state)
        P_CMD: begin
          if (rx_byte inside {CMD_DISP_OFF, CMD_DISP_ON}) nx.display_on = rx_byte[0];
          else if (rx_byte inside {CMD_SEG_REMAP0, CMD_SEG_REMAP1}) nx.seg_remap = rx_byte[0];
          else if (rx_byte inside {CMD_ENTIRE_OFF, CMD_ENTIRE_ON}) nx.entire_on = rx_byte[0];
          else if (rx_byte inside {CMD_COM_SCAN_NORM, CMD_COM_SCAN_REV}) nx.com_scan_rev = rx_byte[3];
          else if (takes_arg(rx_byte)) begin
            nx.state = P_ARG1;
            nx.op = rx_byte;
          end
          else if (rx_byte[7:3] == CMD_PAGE_START[7:3]) nx.page_ptr = rx_byte[PW-1:0];
          else if (rx_byte[7:4] == 4'h0) nx.col_ptr[3:0] = rx_byte[3:0];
          else if (rx_byte[7:3] == 5'b00010) nx.col_ptr[6:4] = rx_byte[2:0];
          else nx_unsup = 1'b1;
        end
        P_ARG1: begin
          nx.state = takes_two(cfg.op) ? P_ARG2 : P_CMD;
          nx.arg1 = rx_byte[6:0];
          if (cfg.op == CMD_CONTRAST) nx.contrast = rx_byte;
          if (cfg.op == CMD_CHARGE_PUMP) nx.charge_pump_en = rx_byte[2];
          if (cfg.op == CMD_ADDR_MODE) nx.addr_mode = &rx_byte[1:0] ? AM_PAGE : addr_mode_t'(rx_byte[1:0]);
        end
        P_ARG2: begin
          nx.state = P_CMD;
          if (cfg.op == CMD_COL_ADDR) begin
            nx.col_start = cfg.arg1;
            nx.col_end = rx_byte[6:0];
            nx.col_ptr = cfg.arg1;
          end
          if (cfg.op == CMD_PAGE_ADDR) begin
            nx.page_start = cfg.arg1[PW-1:0];
            nx.page_end = rx_byte[PW-1:0];
            nx.page_ptr = cfg.arg1[PW-1:0];
          end
        end
        default: nx.state = P_CMD;
      endcase
    end
  end
  // parser register and output strobes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cfg <= CFG_DEF;
      fb_we <= 1'b0;
      unsup <= 1'b0;
      fb_addr <= '0;
      fb_wdata <= '0;
    end else begin
      cfg <= nx;
      fb_we <= nx_we;
      unsup <= nx_unsup;
      fb_addr <= nx_addr;
      fb_wdata <= nx_wdata;
    end
  end
  assign bus.rx_valid = rx_valid;
  assign bus.rx_byte = rx_byte;
  assign bus.rx_is_data = rx_is_data;
  assign bus.display_on = cfg.display_on;
  assign bus.contrast = cfg.contrast;
  assign bus.charge_pump_en = cfg.charge_pump_en;
  assign bus.seg_remap = cfg.seg_remap;
  assign bus.com_scan_rev = cfg.com_scan_rev;
  assign bus.entire_on = cfg.entire_on;
  assign bus.page_ptr = cfg.page_ptr;
  assign bus.col_ptr = cfg.col_ptr;
  assign bus.fb_we = fb_we;
  assign bus.fb_addr = fb_addr;
  assign bus.fb_wdata = fb_wdata;
  assign bus.unsupported_cmd = unsup;
endmodule
